// File: rtl/sram_tmpl_pkg.sv
// Shared SRAM template package: FSM state type and address range check.
// Used by the single-port model and its init controller.
package sram_tmpl_pkg;

  typedef enum logic {
    ST_INIT,
    ST_READY
  } state_t;

  function automatic logic addr_in_range(
    input int unsigned addr,
    input int unsigned depth
  );
    return addr < depth;
  endfunction

endpackage

// File: rtl/sram_init_ctrl.sv
// Post-reset init engine: walks every word once, then reports done.
// Ports: clk, rstb (sync active-low), init_we/init_addr, init_done.
module sram_init_ctrl
  import sram_tmpl_pkg::*;
#(
  parameter int Word_Depth = 128,
  parameter int Add_Width  = 7
) (
  input  logic                 clk,
  input  logic                 rstb,
  output logic                 init_we,
  output logic [Add_Width-1:0] init_addr,
  output logic                 init_done
);

  localparam logic [Add_Width-1:0] LastAddr =
    Add_Width'(Word_Depth - 1);

  state_t               state;
  state_t               state_nxt;
  logic [Add_Width-1:0] cnt;
  logic [Add_Width-1:0] cnt_nxt;

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state     <= ST_INIT;
      cnt       <= '0;
      init_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      // done follows the cycle after the last init write
      init_done <= (state == ST_READY);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    init_we   = 1'b0;
    unique case (state)
      ST_INIT: begin
        init_we = 1'b1;
        if (cnt == LastAddr) begin
          state_nxt = ST_READY;
        end else begin
          cnt_nxt = cnt + Add_Width'(1);
        end
      end
      ST_READY: begin
        state_nxt = ST_READY;
      end
    endcase
  end

  assign init_addr = cnt;

endmodule

// File: rtl/sram_sp_bwe_init.sv
// Single-port sync SRAM model: bit-masked writes, optional output reg,
// Q hold between reads, Q_VLD pulse and post-reset init of every word.
// Ports: CLK, RSTB, CEB, WEB, A, D, BWEB in; Q, Q_VLD, INIT_DONE out.
module sram_sp_bwe_init
  import sram_tmpl_pkg::*;
#(
  parameter int              Bits       = 64,
  parameter int              Word_Depth = 128,
  parameter int              Add_Width  = 7,
  parameter int              Out_Reg    = 0,
  parameter logic [Bits-1:0] Init_Val   = '0
) (
  input  logic                 CLK,
  input  logic                 RSTB,
  input  logic                 CEB,
  input  logic                 WEB,
  input  logic [Add_Width-1:0] A,
  input  logic [Bits-1:0]      D,
  input  logic [Bits-1:0]      BWEB,
  output logic [Bits-1:0]      Q,
  output logic                 Q_VLD,
  output logic                 INIT_DONE
);

  if (Word_Depth > (1 << Add_Width) || Word_Depth < 1) begin : g_bad
    $fatal(1, "Word_Depth does not fit Add_Width");
  end

  logic [Bits-1:0]      ram [Word_Depth];
  logic                 init_we;
  logic [Add_Width-1:0] init_addr;
  logic                 in_range;
  logic                 accept;
  logic                 rd_fire;
  logic                 wr_fire;
  logic [Bits-1:0]      rd_word;
  logic [Bits-1:0]      merged;
  logic                 we;
  logic [Add_Width-1:0] waddr;
  logic [Bits-1:0]      wdata;
  logic [Bits-1:0]      q1;
  logic                 v1;

  sram_init_ctrl #(
    .Word_Depth(Word_Depth),
    .Add_Width (Add_Width)
  ) u_init (
    .clk      (CLK),
    .rstb     (RSTB),
    .init_we  (init_we),
    .init_addr(init_addr),
    .init_done(INIT_DONE)
  );

  assign in_range = addr_in_range(32'(A), Word_Depth);
  assign accept   = INIT_DONE & ~CEB;
  assign rd_fire  = accept & WEB;
  assign wr_fire  = accept & ~WEB & in_range;

  // out-of-range reads return zero rather than aliasing
  assign rd_word = in_range ? ram[A] : '0;
  assign merged  = (rd_word & BWEB) | (D & ~BWEB);

  assign we    = init_we | wr_fire;
  assign waddr = init_we ? init_addr : A;
  assign wdata = init_we ? Init_Val : merged;

  always_ff @(posedge CLK) begin
    if (we) begin
      ram[waddr] <= wdata;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTB) begin
      q1 <= '0;
      v1 <= 1'b0;
    end else begin
      v1 <= rd_fire;
      if (rd_fire) begin
        q1 <= rd_word;
      end
    end
  end

  if (Out_Reg != 0) begin : g_oreg
    logic [Bits-1:0] q2;
    logic            v2;

    always_ff @(posedge CLK) begin
      if (!RSTB) begin
        q2 <= '0;
        v2 <= 1'b0;
      end else begin
        v2 <= v1;
        if (v1) begin
          q2 <= q1;
        end
      end
    end

    assign Q     = q2;
    assign Q_VLD = v2;
  end else begin : g_nreg
    assign Q     = q1;
    assign Q_VLD = v1;
  end

endmodule

// File: tb/tb_sram_sp_bwe_init.sv
// Bench for sram_sp_bwe_init: default, Out_Reg=1 and depth-100 instances
// driven from one shared stimulus stream.
module tb_sram_sp_bwe_init;

  logic        CLK;
  logic        RSTB;
  logic        CEB;
  logic        WEB;
  logic [6:0]  A;
  logic [63:0] D;
  logic [63:0] BWEB;
  logic [63:0] q0, q1, q2;
  logic        v0, v1, v2;
  logic        d0, d1, d2;

  int nvec  = 0;
  int nfail = 0;

  logic [63:0] m [128];

  typedef struct {
    logic        ceb;
    logic        web;
    logic [6:0]  a;
    logic [63:0] d;
    logic [63:0] bweb;
    logic [63:0] q;
    logic        vld;
  } vec_t;

  vec_t tv [$];

  sram_sp_bwe_init u0 (
    .CLK(CLK), .RSTB(RSTB), .CEB(CEB), .WEB(WEB), .A(A),
    .D(D), .BWEB(BWEB), .Q(q0), .Q_VLD(v0), .INIT_DONE(d0)
  );

  sram_sp_bwe_init #(.Out_Reg(1)) u1 (
    .CLK(CLK), .RSTB(RSTB), .CEB(CEB), .WEB(WEB), .A(A),
    .D(D), .BWEB(BWEB), .Q(q1), .Q_VLD(v1), .INIT_DONE(d1)
  );

  sram_sp_bwe_init #(.Word_Depth(100)) u2 (
    .CLK(CLK), .RSTB(RSTB), .CEB(CEB), .WEB(WEB), .A(A),
    .D(D), .BWEB(BWEB), .Q(q2), .Q_VLD(v2), .INIT_DONE(d2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic vec_t mk(
    input logic ceb, input logic web, input logic [6:0] a,
    input logic [63:0] d, input logic [63:0] bweb,
    input logic [63:0] q, input logic vld
  );
    vec_t v;
    v.ceb = ceb; v.web = web; v.a = a; v.d = d;
    v.bweb = bweb; v.q = q; v.vld = vld;
    return v;
  endfunction

  task automatic chk(
    input string nm, input logic [63:0] act, input logic [63:0] want
  );
    nvec++;
    if (act !== want) begin
      nfail++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(
    input logic ceb, input logic web, input logic [6:0] a,
    input logic [63:0] d, input logic [63:0] bweb
  );
    CEB = ceb; WEB = web; A = a; D = d; BWEB = bweb;
    if (!ceb && !web) m[a] = (m[a] & bweb) | (d & ~bweb);
  endtask

  task automatic idle();
    CEB = 1'b1; WEB = 1'b1; A = '0; D = '0; BWEB = '1;
  endtask

  task automatic rd(input logic [6:0] a);
    drive(1'b0, 1'b1, a, 64'h0, '1);
  endtask

  // counts edges after release until each INIT_DONE is seen high;
  // a user write is held on the bus for the first few init cycles
  task automatic wait_done(output int n0, output int n2, output int vseen);
    n0 = 0; n2 = 0; vseen = 0;
    for (int n = 1; n <= 300; n++) begin
      if (n <= 3) begin
        CEB = 1'b0; WEB = 1'b0; A = 7'd5; D = '1; BWEB = '0;
      end else begin
        idle();
      end
      tick();
      if (!d0 && (v0 || v1 || v2)) vseen++;
      if (d0 && n0 == 0) n0 = n;
      if (d2 && n2 == 0) n2 = n;
      if (n0 != 0 && n2 != 0) break;
    end
  endtask

  initial begin
    int n0, n2, vs;
    vec_t t;
    idle();
    RSTB = 1'b0;
    tick();
    tick();
    chk("rst_q0", q0, 64'h0);
    chk("rst_vld0", {63'b0, v0}, 64'h0);
    chk("rst_done0", {63'b0, d0}, 64'h0);
    chk("rst_q1", q1, 64'h0);
    chk("rst_vld1", {63'b0, v1}, 64'h0);

    RSTB = 1'b1;
    wait_done(n0, n2, vs);
    chk("init_edges_128", 64'(n0), 64'd129);
    chk("init_edges_100", 64'(n2), 64'd101);
    chk("init_no_vld", 64'(vs), 64'd0);
    for (int i = 0; i < 128; i++) m[i] = '0;

    // sweep: every word initialised to zero
    for (int i = 0; i < 128; i++) begin
      rd(7'(i));
      tick();
      chk($sformatf("init_rd_%0d", i), q0, 64'h0);
      chk($sformatf("init_vld_%0d", i), {63'b0, v0}, 64'h1);
    end

    tv.push_back(mk(0, 0, 5, 64'hDEAD_BEEF_0123_4567, 0, 0, 0));
    tv.push_back(mk(0, 1, 5, 0, '1, 64'hDEAD_BEEF_0123_4567, 1));
    tv.push_back(mk(1, 1, 0, 0, '1, 64'hDEAD_BEEF_0123_4567, 0));
    tv.push_back(mk(0, 0, 5, '1, 64'hFFFF_FFFF_0000_0000,
                    64'hDEAD_BEEF_0123_4567, 0));
    tv.push_back(mk(0, 1, 5, 0, '1, 64'hDEAD_BEEF_FFFF_FFFF, 1));
    tv.push_back(mk(0, 0, 5, 0, '1, 64'hDEAD_BEEF_FFFF_FFFF, 0));
    tv.push_back(mk(0, 1, 5, 0, '1, 64'hDEAD_BEEF_FFFF_FFFF, 1));
    tv.push_back(mk(0, 0, 1, 64'h111, 0, 64'hDEAD_BEEF_FFFF_FFFF, 0));
    tv.push_back(mk(0, 0, 2, 64'h222, 0, 64'hDEAD_BEEF_FFFF_FFFF, 0));
    tv.push_back(mk(0, 0, 3, 64'h333, 0, 64'hDEAD_BEEF_FFFF_FFFF, 0));
    tv.push_back(mk(0, 1, 1, 0, '1, 64'h111, 1));
    tv.push_back(mk(0, 1, 2, 0, '1, 64'h222, 1));
    tv.push_back(mk(0, 1, 3, 0, '1, 64'h333, 1));
    tv.push_back(mk(0, 0, 127, 64'hAAAA_AAAA_AAAA_AAAA, 0, 64'h333, 0));
    tv.push_back(mk(0, 1, 127, 0, '1, 64'hAAAA_AAAA_AAAA_AAAA, 1));
    tv.push_back(mk(0, 0, 7, 64'h0F0F_0F0F_0F0F_0F0F,
                    64'h00FF_00FF_00FF_00FF, 64'hAAAA_AAAA_AAAA_AAAA, 0));
    tv.push_back(mk(0, 1, 7, 0, '1, 64'h0F00_0F00_0F00_0F00, 1));
    tv.push_back(mk(1, 0, 7, '1, 0, 64'h0F00_0F00_0F00_0F00, 0));

    for (int i = 0; i < tv.size(); i++) begin
      t = tv[i];
      drive(t.ceb, t.web, t.a, t.d, t.bweb);
      tick();
      chk($sformatf("tv%0d_q", i), q0, t.q);
      chk($sformatf("tv%0d_vld", i), {63'b0, v0}, {63'b0, t.vld});
    end

    // Out_Reg=1: three back-to-back reads
    idle(); tick();
    rd(7'd1); tick();
    chk("oreg_vld_a", {63'b0, v1}, 64'h0);
    rd(7'd2); tick();
    chk("oreg_vld_b", {63'b0, v1}, 64'h1);
    chk("oreg_q1", q1, 64'h111);
    rd(7'd3); tick();
    chk("oreg_vld_c", {63'b0, v1}, 64'h1);
    chk("oreg_q2", q1, 64'h222);
    idle(); tick();
    chk("oreg_vld_d", {63'b0, v1}, 64'h1);
    chk("oreg_q3", q1, 64'h333);
    tick();
    chk("oreg_vld_e", {63'b0, v1}, 64'h0);
    chk("oreg_hold", q1, 64'h333);
    tick();
    chk("oreg_hold2", q1, 64'h333);

    // depth 100: out-of-range read and write
    rd(7'd5); tick();
    chk("d100_rd5", q2, 64'hDEAD_BEEF_FFFF_FFFF);
    rd(7'd120); tick();
    chk("d100_oor_q", q2, 64'h0);
    chk("d100_oor_vld", {63'b0, v2}, 64'h1);
    drive(1'b0, 1'b0, 7'd120, '1, '0); tick();
    chk("d100_wr_vld", {63'b0, v2}, 64'h0);
    for (int i = 0; i < 100; i++) begin
      rd(7'(i));
      tick();
      chk($sformatf("d100_sweep_%0d", i), q2, m[i]);
    end
    rd(7'd120); tick();
    chk("d128_rd120", q0, 64'hFFFF_FFFF_FFFF_FFFF);

    // reset with a read in flight, then reset again mid-init
    rd(7'd5); tick();
    idle();
    RSTB = 1'b0;
    tick();
    chk("rr_q0", q0, 64'h0);
    chk("rr_vld0", {63'b0, v0}, 64'h0);
    chk("rr_vld1", {63'b0, v1}, 64'h0);
    chk("rr_q1", q1, 64'h0);
    chk("rr_done", {63'b0, d0}, 64'h0);
    RSTB = 1'b1;
    for (int i = 0; i < 60; i++) tick();
    chk("mid_done", {63'b0, d0}, 64'h0);
    RSTB = 1'b0;
    tick();
    RSTB = 1'b1;
    wait_done(n0, n2, vs);
    chk("reinit_edges_128", 64'(n0), 64'd129);
    chk("reinit_edges_100", 64'(n2), 64'd101);
    chk("reinit_no_vld", 64'(vs), 64'd0);
    rd(7'd5); tick();
    chk("reinit_rd5", q0, 64'h0);
    chk("reinit_vld5", {63'b0, v0}, 64'h1);
    rd(7'd120); tick();
    chk("reinit_rd120", q0, 64'h0);
    rd(7'd127); tick();
    chk("reinit_rd127", q0, 64'h0);
    idle(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
